write_back: RTL and testbench

//   Write-back (W) stage of the 5-stage MIPS-style pipeline. Selects the value

---
 rtl/pipe_pkg.sv | 10 +
 rtl/wb_mux2.sv | 15 +
 rtl/write_back.sv | 51 +++++
 tb/tb_write_back.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath width, register-address width and
// the hard-wired zero register.
package pipe_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_mux2.sv
// Parameterised 2:1 mux that picks the write-back result.
module wb_mux2 #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = sel ? d1 : d0;
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: selects the committed value, drives the register-file
// write port, and keeps a one-cycle registered copy for forwarding.
module write_back #(
  parameter int unsigned DATA_W     = pipe_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  memToRegW,
  input  logic                  RegWriteW,
  input  logic [DATA_W-1:0]     readDataW,
  input  logic [DATA_W-1:0]     ALUOutW,
  output logic [DATA_W-1:0]     ResultW,
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  RegWriteRF,
  output logic [REG_ADDR_W-1:0] WriteRegRF,
  output logic [DATA_W-1:0]     ResultW_reg,
  output logic                  RegWriteW_reg,
  output logic [REG_ADDR_W-1:0] WriteRegW_reg
);

  import pipe_pkg::*;

  wb_mux2 #(
    .DATA_W(DATA_W)
  ) resultMux (
    .sel(memToRegW),
    .d0 (ALUOutW),
    .d1 (readDataW),
    .y  (ResultW)
  );

  // Register $0 is hard-wired to zero, so writes to it are dropped here.
  always_comb begin
    RegWriteRF = RegWriteW & (WriteRegW != REG_ADDR_W'(REG_ZERO));
    WriteRegRF = WriteRegW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ResultW_reg   <= '0;
      RegWriteW_reg <= 1'b0;
      WriteRegW_reg <= '0;
    end else begin
      ResultW_reg   <= ResultW;
      RegWriteW_reg <= RegWriteRF;
      WriteRegW_reg <= WriteRegW;
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: the driver queues expected results per
// cycle, and a monitor checks them just after each rising edge.
module tb_write_back;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memToRegW = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [31:0] readDataW = '0;
  logic [31:0] ALUOutW = '0;
  logic [4:0]  WriteRegW = '0;
  logic [31:0] ResultW;
  logic        RegWriteRF;
  logic [4:0]  WriteRegRF;
  logic [31:0] ResultW_reg;
  logic        RegWriteW_reg;
  logic [4:0]  WriteRegW_reg;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] resQ;
    logic        weQ;
    logic [4:0]  addrQ;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail = 0;

  write_back dut (
    .memToRegW    (memToRegW),
    .RegWriteW    (RegWriteW),
    .readDataW    (readDataW),
    .ALUOutW      (ALUOutW),
    .ResultW      (ResultW),
    .clk          (clk),
    .reset        (reset),
    .WriteRegW    (WriteRegW),
    .RegWriteRF   (RegWriteRF),
    .WriteRegRF   (WriteRegRF),
    .ResultW_reg  (ResultW_reg),
    .RegWriteW_reg(RegWriteW_reg),
    .WriteRegW_reg(WriteRegW_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // should show during this cycle and right after the next rising edge.
  task automatic drive(input logic rst, input logic m2r, input logic rw,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [31:0] expRes, input logic expWe,
                       input logic [31:0] expResQ, input logic expWeQ,
                       input logic [4:0] expAddrQ);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    memToRegW = m2r;
    RegWriteW = rw;
    readDataW = rd;
    ALUOutW   = alu;
    WriteRegW = wr;
    e.res   = expRes;
    e.we    = expWe;
    e.addr  = wr;
    e.resQ  = expResQ;
    e.weQ   = expWeQ;
    e.addrQ = expAddrQ;
    expQ.push_back(e);
    // Result is combinational: visible well before any clock edge.
    #1 chk("ResultW_noclk", ResultW, expRes);
  endtask

  // Monitor: registered outputs are valid every cycle, so pop on each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("ResultW", ResultW, e.res);
        chk("RegWriteRF", 32'(RegWriteRF), 32'(e.we));
        chk("WriteRegRF", 32'(WriteRegRF), 32'(e.addr));
        chk("ResultW_reg", ResultW_reg, e.resQ);
        chk("RegWriteW_reg", 32'(RegWriteW_reg), 32'(e.weQ));
        chk("WriteRegW_reg", 32'(WriteRegW_reg), 32'(e.addrQ));
      end
    end
  end

  initial begin
    logic        m;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] res;
    logic [4:0]  wr;
    int          waitCycles;

    // rst m2r rw readData      ALUOut        wr | res           we | resQ          weQ addrQ
    drive(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd9,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd9);
    // Reset mid-stream: registers clear, combinational outputs keep following inputs.
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd9,  32'h0000_1234, 1'b1, 32'h0,         1'b0, 5'd0);
    // Load with no write-back still selects load data.
    drive(1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F, 32'h0000_1234, 5'd31, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b0, 5'd31);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 5'd1,  32'h8000_0001, 1'b1, 32'h8000_0001, 1'b1, 5'd1);

    // Toggle the select every cycle; wr=0 on the first pass exercises $0 suppression.
    for (int i = 0; i < 20; i++) begin
      m   = i[0];
      rd  = 32'h1000_0000 + 32'(i);
      alu = 32'h2000_0000 + 32'(i);
      wr  = 5'(i);
      res = m ? rd : alu;
      drive(1'b0, m, 1'b1, rd, alu, wr, res, (i != 0), res, (i != 0), wr);
    end

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
